// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the two-read / one-write register file.
// Imported by regfile_2r1w_if, regfile_rport and regfile_2r1w.
package regfile_pkg;

    localparam int REGFILE_WIDTH_DEF = 32;
    localparam int REGFILE_DEPTH_DEF = 32;

    // Ceiling log2, used to size addresses from DEPTH (DEPTH=2 gives 1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: one write port, two read ports and the
// written bitmap.
//
// Port semantics: there is no backpressure. A write is taken on every
// rising edge where we=1. A read is launched on every rising edge where
// re_x=1, and rdata_x shows the result right after that edge. When re_x=0,
// rdata_x keeps its last value.
interface regfile_2r1w_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = REGFILE_WIDTH_DEF,
    parameter int DEPTH = REGFILE_DEPTH_DEF
) ();
    localparam int AW = clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re_a;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic             re_b;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic [DEPTH-1:0] written;

    // Requester side: drives writes and read requests.
    modport master (
        output we, waddr, wdata,
        output re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, rdata_b, written
    );

    // Register file side.
    modport slave (
        input  we, waddr, wdata,
        input  re_a, raddr_a, re_b, raddr_b,
        output rdata_a, rdata_b, written
    );
endinterface

// File: rtl/regfile_rport.sv
// One registered read port: it selects the addressed register, forwards
// same-edge write data (write-first), and holds its output while disabled.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int               WIDTH = REGFILE_WIDTH_DEF,
    parameter int               DEPTH = REGFILE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] INIT  = '0,
    localparam int              AW    = clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        re,
    input  logic [AW-1:0]               raddr,
    input  logic [DEPTH-1:0][WIDTH-1:0] regs,
    // we must already be qualified: a write that will be discarded must not be forwarded.
    input  logic                        we,
    input  logic [AW-1:0]               waddr,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Next read data: hold when disabled, forward a colliding write, otherwise read the array.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            if (we && (waddr == raddr)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = regs[raddr];
            end
        end
    end

    // Output register; reset loads INIT so the port never shows X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= INIT;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered read ports and a
// per-register "written since reset" bitmap.
// Optional macro REGFILE_ZERO_REG_EN makes register 0 a constant zero. Writes
// to address 0 are then dropped, never forwarded and never marked written.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int               WIDTH = REGFILE_WIDTH_DEF,
    parameter int               DEPTH = REGFILE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input logic           clk,
    input logic           rst,
    regfile_2r1w_if.slave bus
);

    localparam int AW = clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] regs_q;
    logic [DEPTH-1:0][WIDTH-1:0] regs_d;
    logic [DEPTH-1:0]            written_q;
    logic [DEPTH-1:0]            written_d;
    logic                        wr_en;
    logic [WIDTH-1:0]            rdata_a;
    logic [WIDTH-1:0]            rdata_b;

    // Qualify the write; with the zero register, address 0 is never writable.
    always_comb begin
        wr_en = bus.we;
`ifdef REGFILE_ZERO_REG_EN
        if (bus.waddr == AW'(0)) begin
            wr_en = 1'b0;
        end
`else
`endif
    end

    // Next array contents and written bitmap; bits only ever set here.
    always_comb begin
        regs_d    = regs_q;
        written_d = written_q;
        if (wr_en) begin
            regs_d[bus.waddr]    = bus.wdata;
            written_d[bus.waddr] = 1'b1;
        end
    end

    // Storage and bitmap; asynchronous reset overrides any write on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q    <= {DEPTH{INIT}};
`ifdef REGFILE_ZERO_REG_EN
            regs_q[0] <= '0;
`else
`endif
            written_q <= '0;
        end else begin
            regs_q    <= regs_d;
            written_q <= written_d;
        end
    end

    regfile_rport #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INIT  (INIT)
    ) u_rport_a (
        .clk   (clk),
        .rst   (rst),
        .re    (bus.re_a),
        .raddr (bus.raddr_a),
        .regs  (regs_q),
        .we    (wr_en),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .rdata (rdata_a)
    );

    regfile_rport #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INIT  (INIT)
    ) u_rport_b (
        .clk   (clk),
        .rst   (rst),
        .re    (bus.re_b),
        .raddr (bus.raddr_b),
        .regs  (regs_q),
        .we    (wr_en),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .rdata (rdata_b)
    );

    assign bus.rdata_a = rdata_a;
    assign bus.rdata_b = rdata_b;
    assign bus.written = written_q;

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits of every register.
REQ-002 Parameter DEPTH, default 32, number of registers; power of two, 2 to 256.
REQ-003 Parameter INIT, default 32'h0000_0000 (WIDTH bits), value loaded into every register on reset.
REQ-004 Derived constant AW = clog2(DEPTH), address width; not user-settable.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 we  in  1  write enable.
REQ-008 waddr  in  AW  write address.
REQ-009 wdata  in  WIDTH  write data.
REQ-010 re_a / re_b  in  1  read enable, ports A / B.
REQ-011 raddr_a / raddr_b  in  AW  read address, ports A / B.
REQ-012 rdata_a / rdata_b  out  WIDTH  registered read data, ports A / B.
REQ-013 written  out  DEPTH  bit i high once register i has been written since reset.

Function
REQ-014 Write: on a rising clk edge with we=1, register[waddr] SHALL take wdata and written[waddr] SHALL set; with we=0 no register changes.
REQ-015 Read latency SHALL be one cycle: with re_x=1 at edge N, rdata_x SHALL show register[raddr_x] from edge N onward.
REQ-016 With re_x=0 at an edge, rdata_x SHALL hold its previous value (no high-Z, no X).
REQ-017 Bypass: same-edge we=1, re_x=1, waddr==raddr_x SHALL give rdata_x = wdata (write-first).
REQ-018 Ports A and B SHALL be independent; both may read the same address in the same cycle with identical results.
REQ-019 written bits SHALL only set, never clear, except on reset.
REQ-020 No out-of-range address exists (DEPTH is a power of two); no error flag is required.

Reset
REQ-021 While rst=1, every register SHALL equal INIT, rdata_a and rdata_b SHALL equal INIT, written SHALL be all zeros, independent of clk.
REQ-022 rst asserted mid-write SHALL win; the write SHALL be lost.
REQ-023 First edge after rst deasserts SHALL act as a normal cycle.

Configuration
REQ-024 Macro REGFILE_ZERO_REG_EN: when defined, register 0 SHALL read as all zeros always, writes to address 0 SHALL be discarded (no bypass of wdata, written[0] stays 0), and reset leaves register 0 at zero regardless of INIT.
REQ-025 When REGFILE_ZERO_REG_EN is not defined, register 0 SHALL behave as any other register.

Structure
REQ-026 Package regfile_pkg SHALL hold REGFILE_WIDTH_DEF=32, REGFILE_DEPTH_DEF=32 and the clog2 helper used for AW.
REQ-027 Sub-module regfile_rport SHALL implement one read port (address select, bypass compare, enable-hold output register) and be instantiated twice.
REQ-028 Storage array, write logic and the written bitmap SHALL live in regfile_2r1w.

Verification
REQ-029 Reset: rst=1 with INIT=32'h0040_0000 -> rdata_a=rdata_b=32'h0040_0000, written=0; a read of any address after release -> 32'h0040_0000.
REQ-030 Write/read: we=1 waddr=5 wdata=32'hDEAD_BEEF, next cycle re_a=1 raddr_a=5 -> rdata_a=32'hDEAD_BEEF one edge later, written[5]=1.
REQ-031 Bypass: we=1 waddr=7 wdata=32'h1234_5678 with re_b=1 raddr_b=7 same edge -> rdata_b=32'h1234_5678 after that edge.
REQ-032 Hold: rdata_a=32'hDEAD_BEEF, then re_a=0 while register 5 is rewritten to 32'h0 -> rdata_a stays 32'hDEAD_BEEF until re_a=1.
REQ-033 Zero register (macro defined): we=1 waddr=0 wdata=32'hFFFF_FFFF with re_a=1 raddr_a=0 -> rdata_a=0 now and on every later read, written[0]=0.
REQ-034 Reset mid-op: rst pulsed between edges while we=1 waddr=3 wdata=32'hA5A5_A5A5 -> register 3 reads INIT, written[3]=0.
